// File: rtl/avs_accel_pkg.sv
// Shared register map, CTRL/STATUS bit positions and run-FSM encoding for the accelerator CSR slave.
package avs_accel_pkg;

   localparam int CTRL_IDX     = 0;
   localparam int STATUS_IDX   = 1;
   localparam int TLIM_IDX     = 2;
   localparam int CCNT_IDX     = 3;
   localparam int ARG_BASE_IDX = 4;

   localparam int CTRL_START_BIT  = 0;
   localparam int CTRL_IRQ_EN_BIT = 1;
   localparam int CTRL_ABORT_BIT  = 2;

   localparam int STAT_BUSY_BIT    = 0;
   localparam int STAT_DONE_BIT    = 1;
   localparam int STAT_TIMEOUT_BIT = 2;

   typedef enum logic [0:0] {
      RUN_IDLE = 1'b0,
      RUN_BUSY = 1'b1
   } run_state_t;

   // Single-cycle events raised by the run controller towards the register file.
   typedef struct packed {
      logic start;
      logic done;
      logic timeout;
   } run_evt_t;

endpackage

// File: rtl/avs_accel_run_ctrl.sv
// Run controller: IDLE/BUSY FSM, saturating busy-cycle counter and timeout compare.
// START/ABORT pulses are registered, one cycle after the causing event; no backpressure.
module avs_accel_run_ctrl
   import avs_accel_pkg::*;
#(
   parameter int DATA_WIDTH = 32
)
(
   input  logic                  CSI_CLOCK_CLK,
   input  logic                  CSI_CLOCK_RESET,
   input  logic                  start_req,
   input  logic                  abort_req,
   input  logic                  done,
   input  logic [DATA_WIDTH-1:0] timeout_limit,
   output logic                  busy,
   output logic                  start_pulse,
   output logic                  abort_pulse,
   output run_evt_t              evt,
   output logic [DATA_WIDTH-1:0] cycle_count
);

   run_state_t            state_q;
   run_state_t            state_d;
   logic [DATA_WIDTH-1:0] count_q;
   logic                  start_q;
   logic                  abort_q;
   logic                  abort_evt;
   logic                  timeout_hit;

   assign timeout_hit = (timeout_limit != '0) && (count_q == timeout_limit);

   always_comb begin
      state_d   = state_q;
      evt       = '0;
      abort_evt = 1'b0;
      case (state_q)
         RUN_IDLE: begin
            if (start_req) begin
               evt.start = 1'b1;
               state_d   = RUN_BUSY;
            end
         end
         RUN_BUSY: begin
            // Completion beats timeout beats a host abort in the same cycle.
            if (done) begin
               evt.done = 1'b1;
               state_d  = RUN_IDLE;
            end else if (timeout_hit) begin
               evt.timeout = 1'b1;
               state_d     = RUN_IDLE;
            end else if (abort_req) begin
               abort_evt = 1'b1;
               state_d   = RUN_IDLE;
            end
         end
         default: state_d = RUN_IDLE;
      endcase
   end

   always_ff @(posedge CSI_CLOCK_CLK) begin
      if (CSI_CLOCK_RESET) begin
         state_q <= RUN_IDLE;
         count_q <= '0;
         start_q <= 1'b0;
         abort_q <= 1'b0;
      end else begin
         state_q <= state_d;
         start_q <= evt.start;
         abort_q <= evt.timeout | abort_evt;
         // The exiting cycle is not counted, so the count equals the limit on timeout.
         if (evt.start) begin
            count_q <= '0;
         end else if (state_q == RUN_BUSY && state_d == RUN_BUSY && count_q != '1) begin
            count_q <= count_q + DATA_WIDTH'(1);
         end
      end
   end

   assign busy        = (state_q == RUN_BUSY);
   assign start_pulse = start_q;
   assign abort_pulse = abort_q;
   assign cycle_count = count_q;

endmodule

// File: rtl/avs_accel_ctrl_slave.sv
// Avalon-MM CSR slave fronting an accelerator: args, results, control/status, timeout, IRQ.
// Fixed 1-cycle read latency; WAITREQUEST tied low, every transfer accepted on its strobe cycle.
module avs_accel_ctrl_slave
   import avs_accel_pkg::*;
#(
   parameter int DATA_WIDTH    = 32,
   parameter int ADDRESS_WIDTH = 6,
   parameter int NUM_ARGS      = 8,
   parameter int NUM_RESULTS   = 4
)
(
   input  logic                              CSI_CLOCK_CLK,
   input  logic                              CSI_CLOCK_RESET,
   input  logic [ADDRESS_WIDTH-1:0]          AVS_AVALONSLAVE_ADDRESS,
   input  logic                              AVS_AVALONSLAVE_READ,
   input  logic                              AVS_AVALONSLAVE_WRITE,
   input  logic [DATA_WIDTH/8-1:0]           AVS_AVALONSLAVE_BYTEENABLE,
   input  logic [DATA_WIDTH-1:0]             AVS_AVALONSLAVE_WRITEDATA,
   output logic [DATA_WIDTH-1:0]             AVS_AVALONSLAVE_READDATA,
   output logic                              AVS_AVALONSLAVE_READDATAVALID,
   output logic                              AVS_AVALONSLAVE_WAITREQUEST,
   output logic                              INS_IRQ_IRQ,
   output logic                              START,
   output logic                              ABORT,
   input  logic                              DONE,
   input  logic [NUM_RESULTS*DATA_WIDTH-1:0] RESULTS,
   output logic [NUM_ARGS*DATA_WIDTH-1:0]    ARGS
);

   localparam int NUM_LANES       = DATA_WIDTH / 8;
   localparam int RESULT_BASE_IDX = ARG_BASE_IDX + NUM_ARGS;

   logic [31:0]           word_idx;
   logic                  wr_en;
   logic                  rd_en;
   logic                  ctrl_wr;
   logic                  status_wr;
   logic                  start_req;
   logic                  abort_req;
   logic                  busy;
   run_evt_t              evt;
   logic [DATA_WIDTH-1:0] cycle_count;

   logic [DATA_WIDTH-1:0] arg_q [NUM_ARGS];
   logic [DATA_WIDTH-1:0] result_q [NUM_RESULTS];
   logic [DATA_WIDTH-1:0] tlim_q;
   logic                  irq_en_q;
   logic                  done_sticky_q;
   logic                  timeout_sticky_q;
   logic                  irq_q;
   logic                  rdv_q;
   logic [DATA_WIDTH-1:0] rdata_q;
   logic [DATA_WIDTH-1:0] rdata_d;

   function automatic logic [DATA_WIDTH-1:0] merge_lanes(
      input logic [DATA_WIDTH-1:0] cur,
      input logic [DATA_WIDTH-1:0] wdat,
      input logic [NUM_LANES-1:0]  be
   );
      logic [DATA_WIDTH-1:0] res;
      res = cur;
      for (int b = 0; b < NUM_LANES; b++) begin
         if (be[b]) res[8*b +: 8] = wdat[8*b +: 8];
      end
      return res;
   endfunction

   assign word_idx  = 32'(AVS_AVALONSLAVE_ADDRESS >> 2);
   assign wr_en     = AVS_AVALONSLAVE_WRITE;
   assign rd_en     = AVS_AVALONSLAVE_READ & ~AVS_AVALONSLAVE_WRITE;
   assign ctrl_wr   = wr_en & AVS_AVALONSLAVE_BYTEENABLE[0] & (word_idx == CTRL_IDX);
   assign status_wr = wr_en & AVS_AVALONSLAVE_BYTEENABLE[0] & (word_idx == STATUS_IDX);
   assign start_req = ctrl_wr & AVS_AVALONSLAVE_WRITEDATA[CTRL_START_BIT];
   assign abort_req = ctrl_wr & AVS_AVALONSLAVE_WRITEDATA[CTRL_ABORT_BIT];

   avs_accel_run_ctrl #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_run_ctrl (
      .CSI_CLOCK_CLK   (CSI_CLOCK_CLK),
      .CSI_CLOCK_RESET (CSI_CLOCK_RESET),
      .start_req       (start_req),
      .abort_req       (abort_req),
      .done            (DONE),
      .timeout_limit   (tlim_q),
      .busy            (busy),
      .start_pulse     (START),
      .abort_pulse     (ABORT),
      .evt             (evt),
      .cycle_count     (cycle_count)
   );

   always_comb begin
      rdata_d = '0;
      if (rd_en) begin
         if (word_idx == CTRL_IDX) begin
            rdata_d[CTRL_IRQ_EN_BIT] = irq_en_q;
         end else if (word_idx == STATUS_IDX) begin
            rdata_d[STAT_BUSY_BIT]    = busy;
            rdata_d[STAT_DONE_BIT]    = done_sticky_q;
            rdata_d[STAT_TIMEOUT_BIT] = timeout_sticky_q;
         end else if (word_idx == TLIM_IDX) begin
            rdata_d = tlim_q;
         end else if (word_idx == CCNT_IDX) begin
            rdata_d = cycle_count;
         end
         for (int k = 0; k < NUM_ARGS; k++) begin
            if (word_idx == ARG_BASE_IDX + k) rdata_d = arg_q[k];
         end
         for (int k = 0; k < NUM_RESULTS; k++) begin
            if (word_idx == RESULT_BASE_IDX + k) rdata_d = result_q[k];
         end
      end
   end

   always_ff @(posedge CSI_CLOCK_CLK) begin
      if (CSI_CLOCK_RESET) begin
         for (int k = 0; k < NUM_ARGS; k++) arg_q[k] <= '0;
         for (int k = 0; k < NUM_RESULTS; k++) result_q[k] <= '0;
         tlim_q           <= '0;
         irq_en_q         <= 1'b0;
         done_sticky_q    <= 1'b0;
         timeout_sticky_q <= 1'b0;
         irq_q            <= 1'b0;
         rdv_q            <= 1'b0;
         rdata_q          <= '0;
      end else begin
         if (wr_en && word_idx == TLIM_IDX) begin
            tlim_q <= merge_lanes(tlim_q, AVS_AVALONSLAVE_WRITEDATA, AVS_AVALONSLAVE_BYTEENABLE);
         end
         for (int k = 0; k < NUM_ARGS; k++) begin
            if (wr_en && word_idx == ARG_BASE_IDX + k) begin
               arg_q[k] <= merge_lanes(arg_q[k], AVS_AVALONSLAVE_WRITEDATA, AVS_AVALONSLAVE_BYTEENABLE);
            end
         end
         if (evt.done) begin
            for (int k = 0; k < NUM_RESULTS; k++) result_q[k] <= RESULTS[k*DATA_WIDTH +: DATA_WIDTH];
         end
         if (ctrl_wr) irq_en_q <= AVS_AVALONSLAVE_WRITEDATA[CTRL_IRQ_EN_BIT];

         // Hardware set takes precedence over a same-cycle W1C from the host.
         if (evt.start) begin
            done_sticky_q <= 1'b0;
         end else if (evt.done) begin
            done_sticky_q <= 1'b1;
         end else if (status_wr && AVS_AVALONSLAVE_WRITEDATA[STAT_DONE_BIT]) begin
            done_sticky_q <= 1'b0;
         end
         if (evt.start) begin
            timeout_sticky_q <= 1'b0;
         end else if (evt.timeout) begin
            timeout_sticky_q <= 1'b1;
         end else if (status_wr && AVS_AVALONSLAVE_WRITEDATA[STAT_TIMEOUT_BIT]) begin
            timeout_sticky_q <= 1'b0;
         end

         irq_q   <= irq_en_q & (done_sticky_q | timeout_sticky_q);
         rdv_q   <= rd_en;
         rdata_q <= rdata_d;
      end
   end

   for (genvar k = 0; k < NUM_ARGS; k++) begin : g_args
      assign ARGS[k*DATA_WIDTH +: DATA_WIDTH] = arg_q[k];
   end

   assign AVS_AVALONSLAVE_READDATA      = rdata_q;
   assign AVS_AVALONSLAVE_READDATAVALID = rdv_q;
   assign AVS_AVALONSLAVE_WAITREQUEST   = 1'b0;
   assign INS_IRQ_IRQ                   = irq_q;

endmodule

// File: tb/tb_avs_accel_ctrl_slave.sv
// Self-checking bench for avs_accel_ctrl_slave: read data scoreboarded, pulses and IRQ sampled on the falling edge.
module tb_avs_accel_ctrl_slave;

   localparam logic [5:0] A_CTRL   = 6'h00;
   localparam logic [5:0] A_STATUS = 6'h04;
   localparam logic [5:0] A_TLIM   = 6'h08;
   localparam logic [5:0] A_CCNT   = 6'h0C;
   localparam logic [5:0] A_ARG0   = 6'h10;
   localparam logic [5:0] A_ARG1   = 6'h14;
   localparam logic [5:0] A_ARG2   = 6'h18;
   localparam logic [5:0] A_ARG7   = 6'h2C;
   localparam logic [5:0] A_RES0   = 6'h30;
   localparam logic [5:0] A_RES3   = 6'h3C;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic [5:0]   address = '0;
   logic         read = 1'b0;
   logic         write = 1'b0;
   logic [3:0]   byteenable = '0;
   logic [31:0]  writedata = '0;
   logic [31:0]  readdata;
   logic         rdv;
   logic         waitreq;
   logic         irq;
   logic         start;
   logic         abort;
   logic         done = 1'b0;
   logic [127:0] results = '0;
   logic [255:0] args;

   int           n_checks = 0;
   int           n_fail = 0;
   int           start_cnt = 0;
   int           abort_cnt = 0;
   logic         rd_issued = 1'b0;
   logic [31:0]  exp_q[$];
   string        tag_q[$];

   avs_accel_ctrl_slave dut (
      .CSI_CLOCK_CLK                 (clk),
      .CSI_CLOCK_RESET               (rst),
      .AVS_AVALONSLAVE_ADDRESS       (address),
      .AVS_AVALONSLAVE_READ          (read),
      .AVS_AVALONSLAVE_WRITE         (write),
      .AVS_AVALONSLAVE_BYTEENABLE    (byteenable),
      .AVS_AVALONSLAVE_WRITEDATA     (writedata),
      .AVS_AVALONSLAVE_READDATA      (readdata),
      .AVS_AVALONSLAVE_READDATAVALID (rdv),
      .AVS_AVALONSLAVE_WAITREQUEST   (waitreq),
      .INS_IRQ_IRQ                   (irq),
      .START                         (start),
      .ABORT                         (abort),
      .DONE                          (done),
      .RESULTS                       (results),
      .ARGS                          (args)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
      end
   endtask

   task automatic bus_write(input logic [5:0] addr, input logic [31:0] data, input logic [3:0] be);
      address    = addr;
      writedata  = data;
      byteenable = be;
      write      = 1'b1;
      @(posedge clk);
      #1;
      write      = 1'b0;
      byteenable = '0;
      writedata  = '0;
   endtask

   task automatic bus_read(input logic [5:0] addr, input logic [31:0] exp, input string tag);
      address = addr;
      read    = 1'b1;
      exp_q.push_back(exp);
      tag_q.push_back(tag);
      @(posedge clk);
      #1;
      read = 1'b0;
   endtask

   task automatic cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Reference pipe of the host strobes: a read is due back exactly one cycle later.
   always @(posedge clk) rd_issued <= rst ? 1'b0 : (read & ~write);

   always @(negedge clk) begin
      logic [31:0] e;
      string       t;
      if (rd_issued || rdv) check_eq("rdv_timing", 32'(rdv), 32'(rd_issued));
      if (rd_issued && exp_q.size() > 0) begin
         e = exp_q.pop_front();
         t = tag_q.pop_front();
         if (rdv) check_eq(t, readdata, e);
      end
      if (!rdv) check_eq("rdata_idle_zero", readdata, 32'h0);
      check_eq("waitrequest", 32'(waitreq), 32'h0);
   end

   always @(negedge clk) begin
      if (start) start_cnt++;
      if (abort) abort_cnt++;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int base_abort;
      int base_start;
      int lat;

      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check_eq("rst_start", 32'(start), 32'h0);
      check_eq("rst_abort", 32'(abort), 32'h0);
      check_eq("rst_irq", 32'(irq), 32'h0);
      check_eq("rst_args", args[31:0], 32'h0);
      @(posedge clk);
      #1;
      bus_read(A_CTRL, 32'h0, "rst_ctrl");
      bus_read(A_STATUS, 32'h0, "rst_status");
      bus_read(A_CCNT, 32'h0, "rst_ccnt");
      bus_read(A_RES0, 32'h0, "rst_res0");

      // Byte-lane writes
      bus_write(A_ARG0, 32'hDEADBEEF, 4'b0101);
      bus_read(A_ARG0, 32'h00AD00EF, "arg0_be0101");
      bus_write(A_ARG1, 32'hCAFEF00D, 4'b1111);
      bus_write(A_ARG7, 32'h11223344, 4'b1010);
      bus_read(A_ARG1, 32'hCAFEF00D, "arg1_full");
      bus_read(A_ARG7, 32'h11003300, "arg7_be1010");
      bus_write(A_TLIM, 32'h12345678, 4'b1100);
      bus_read(A_TLIM, 32'h12340000, "tlim_be1100");
      bus_write(A_TLIM, 32'h0, 4'b1111);
      @(negedge clk);
      check_eq("args_port_arg0", args[31:0], 32'h00AD00EF);
      check_eq("args_port_arg7", args[255:224], 32'h11003300);
      @(posedge clk);
      #1;

      // Simultaneous read and write: write lands, no read response
      address = A_ARG2; writedata = 32'h55AA55AA; byteenable = 4'hF;
      read = 1'b1; write = 1'b1;
      @(posedge clk);
      #1;
      read = 1'b0; write = 1'b0; byteenable = '0;
      bus_read(A_ARG2, 32'h55AA55AA, "rw_collision_arg2");

      // Normal run completed by DONE
      results = {32'h0BADF00D, 32'h0, 32'h0000A5A5, 32'h00001234};
      base_start = start_cnt;
      bus_write(A_CTRL, 32'h3, 4'b0001);
      @(negedge clk);
      check_eq("start_pulse", 32'(start), 32'h1);
      @(posedge clk);
      #1;
      cycles(3);
      bus_read(A_STATUS, 32'h1, "status_busy");
      bus_write(A_CTRL, 32'h3, 4'b0001);
      cycles(5);
      done = 1'b1;
      @(posedge clk);
      #1 done = 1'b0;
      results = {32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hEEEEEEEE};
      bus_read(A_STATUS, 32'h2, "status_done");
      bus_read(A_CCNT, 32'd11, "ccnt_done");
      bus_read(A_RES0, 32'h1234, "res0_done");
      bus_read(A_RES3, 32'h0BADF00D, "res3_done");
      bus_read(A_CTRL, 32'h2, "ctrl_irq_en");
      @(negedge clk);
      check_eq("irq_after_done", 32'(irq), 32'h1);
      check_eq("start_once", 32'(start_cnt - base_start), 32'h1);
      @(posedge clk);
      #1;

      // W1C behaviour and DONE in IDLE
      bus_write(A_STATUS, 32'h2, 4'b0000);
      bus_read(A_STATUS, 32'h2, "w1c_no_be0");
      bus_write(A_STATUS, 32'h0, 4'b0001);
      bus_read(A_STATUS, 32'h2, "w0_no_effect");
      bus_write(A_STATUS, 32'h2, 4'b0001);
      @(posedge clk);
      @(negedge clk);
      check_eq("irq_cleared", 32'(irq), 32'h0);
      @(posedge clk);
      #1;
      bus_read(A_STATUS, 32'h0, "status_cleared");
      done = 1'b1;
      @(posedge clk);
      #1 done = 1'b0;
      bus_read(A_RES0, 32'h1234, "done_in_idle_res0");
      bus_read(A_STATUS, 32'h0, "done_in_idle_status");

      // Timeout
      bus_write(A_TLIM, 32'd5, 4'b1111);
      base_abort = abort_cnt;
      bus_write(A_CTRL, 32'h1, 4'b0001);
      lat = 0;
      for (int i = 1; i <= 20; i++) begin
         @(negedge clk);
         if (abort && lat == 0) lat = i;
      end
      @(posedge clk);
      #1;
      check_eq("timeout_abort_latency", 32'(lat), 32'd7);
      check_eq("timeout_abort_once", 32'(abort_cnt - base_abort), 32'h1);
      bus_read(A_STATUS, 32'h4, "status_timeout");
      bus_read(A_CCNT, 32'd5, "ccnt_timeout");
      bus_read(A_TLIM, 32'd5, "tlim_readback");
      check_eq("irq_disabled", 32'(irq), 32'h0);

      // DONE and ABORT write together: DONE wins
      bus_write(A_TLIM, 32'h0, 4'b1111);
      results = {32'h0, 32'h0, 32'h0, 32'h00005678};
      base_abort = abort_cnt;
      bus_write(A_CTRL, 32'h3, 4'b0001);
      cycles(3);
      done = 1'b1;
      bus_write(A_CTRL, 32'h4, 4'b0001);
      done = 1'b0;
      cycles(2);
      check_eq("done_beats_abort", 32'(abort_cnt - base_abort), 32'h0);
      bus_read(A_STATUS, 32'h2, "status_done_vs_abort");
      bus_read(A_RES0, 32'h5678, "res0_done_vs_abort");
      bus_read(A_CCNT, 32'd3, "ccnt_short_run");

      // Host abort while BUSY, then abort while IDLE
      results = {32'h0, 32'h0, 32'h0, 32'h99999999};
      bus_write(A_CTRL, 32'h1, 4'b0001);
      cycles(2);
      base_abort = abort_cnt;
      bus_write(A_CTRL, 32'h4, 4'b0001);
      cycles(2);
      check_eq("host_abort_pulse", 32'(abort_cnt - base_abort), 32'h1);
      bus_read(A_STATUS, 32'h0, "status_after_abort");
      bus_read(A_RES0, 32'h5678, "res0_after_abort");
      base_abort = abort_cnt;
      bus_write(A_CTRL, 32'h4, 4'b0001);
      cycles(2);
      check_eq("abort_idle_ignored", 32'(abort_cnt - base_abort), 32'h0);
      check_eq("total_starts", 32'(start_cnt - base_start), 32'd4);

      // Reset in the middle of a run
      bus_write(A_TLIM, 32'd100, 4'b1111);
      bus_write(A_CTRL, 32'h3, 4'b0001);
      cycles(3);
      base_abort = abort_cnt;
      rst = 1'b1;
      cycles(2);
      rst = 1'b0;
      cycles(2);
      check_eq("reset_no_abort", 32'(abort_cnt - base_abort), 32'h0);
      check_eq("reset_irq", 32'(irq), 32'h0);
      check_eq("reset_args_port", args[31:0], 32'h0);
      bus_read(A_CTRL, 32'h0, "mrst_ctrl");
      bus_read(A_STATUS, 32'h0, "mrst_status");
      bus_read(A_TLIM, 32'h0, "mrst_tlim");
      bus_read(A_CCNT, 32'h0, "mrst_ccnt");
      bus_read(A_ARG1, 32'h0, "mrst_arg1");
      bus_read(A_RES0, 32'h0, "mrst_res0");
      bus_read(6'h3F, 32'h0, "mrst_word_3f");

      cycles(3);
      check_eq("scoreboard_drained", 32'(exp_q.size()), 32'h0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
